unpool_layer: RTL
=================

UNPOOL_LAYER -- requirements
Module: unpool_layer

Interface
REQ-001 Parameter DATA_W, default 32, signed feature-map element width.
REQ-002 Parameter IN_W, default 3, input feature-map width in pixels.
REQ-003 Parameter IN_H, default 3, input feature-map height in pixels.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin one IN_W x IN_H -> 2IN_W x 2IN_H frame; sampled in IDLE only.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  DATA_W  signed input pixel, raster order.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  DATA_W  signed upsampled pixel, raster order.
REQ-013 out_last  output  1  high with the final (2IN_W*2IN_H-th) output pixel.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the frame's last output transfer.

Function
REQ-016 FSM states: IDLE, FILL, EMIT0, EMIT1, DONE; the block SHALL not overlap input fill with output emission.
REQ-017 IDLE: start=1 -> FILL with irow=0, icol=0, orow=0, ocol=0; start while not IDLE is ignored.
REQ-018 FILL: in_ready=1; on in_valid&&in_ready, line_buf[icol]<=in_data and icol increments; transfer at icol==IN_W-1 -> EMIT0, icol<=0.
REQ-019 EMIT0/EMIT1: out_valid=1, in_ready=0; out_data = line_buf[ocol>>1] (nearest-neighbour 2x2 replication).
REQ-020 Output transfer occurs on out_valid&&out_ready; ocol increments; out_data and out_valid SHALL hold stable while out_ready=0.
REQ-021 EMIT0 transfer at ocol==2IN_W-1 -> EMIT1, ocol<=0 (same buffered row emitted again).
REQ-022 EMIT1 transfer at ocol==2IN_W-1: if irow<IN_H-1 -> FILL, irow++; else -> DONE.
REQ-023 out_last=1 only in EMIT1 with irow==IN_H-1 and ocol==2IN_W-1.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 First out_valid SHALL assert the cycle after the row's last input transfer; with in_valid and out_ready held high, a default frame takes 45 cycles from FILL entry to DONE.
REQ-026 Exactly IN_W*IN_H input transfers and 4*IN_W*IN_H output transfers per frame; no arithmetic is applied; values pass bit-exact.

Reset
REQ-027 rst SHALL force IDLE and clear in_ready, out_valid, out_last, busy, done and all counters; line_buf contents are don't-care.
REQ-028 rst mid-frame SHALL abandon the frame with no done pulse; next start begins a fresh frame.

Configuration
REQ-029 Macro UNPOOL_ZERO_FILL_EN defined: out_data = line_buf[ocol>>1] only in EMIT0 at even ocol, else 0 (max-unpool-style top-left placement).
REQ-030 Macro UNPOOL_ZERO_FILL_EN undefined: replication per REQ-019; timing, handshake and counts identical in both builds.

Structure
REQ-031 Shared package cnn_pkg SHALL hold DATA_W default, default feature-map dimension constants, and the unpool state enum typedef.
REQ-032 One sub-module, unpool_line_buf: IN_W x DATA_W register array with indexed write port and indexed combinational read port.

Verification
REQ-033 Defaults, in_valid/out_ready always 1, inputs 1..9 -> output row0 = 1,1,2,2,3,3, row1 identical, row5 = 7,7,8,8,9,9; out_last on 36th; done 1 cycle; 45 cycles.
REQ-034 out_ready toggled 1/0 every cycle, inputs -5,0,7,... -> 36 transfers, out_data stable during stalls, negatives exact.
REQ-035 UNPOOL_ZERO_FILL_EN, inputs 1..9 -> row0 = 1,0,2,0,3,0; row1 all 0; 27 zero outputs total.
REQ-036 rst asserted after 20 outputs -> next cycle busy=0, out_valid=0, no done; new start with inputs 10..18 -> first outputs 10,10,11,11.
REQ-037 start pulsed during EMIT0 and in_valid driven in EMIT states -> ignored; in_ready=0; frame output unchanged.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default element width, default feature-map size and
// the unpool FSM state type.
package cnn_pkg;

   localparam int CNN_DATA_W = 32;
   localparam int CNN_IN_W   = 3;
   localparam int CNN_IN_H   = 3;

   typedef enum logic [2:0] {
      UNPOOL_IDLE,
      UNPOOL_FILL,
      UNPOOL_EMIT0,
      UNPOOL_EMIT1,
      UNPOOL_DONE
   } unpool_state_e;

   // Index width that stays at least one bit for degenerate one-entry ranges
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/unpool_line_buf.sv
// One-row line buffer: DEPTH signed registers with an indexed write port and
// an indexed combinational read port.
module unpool_line_buf
   import cnn_pkg::*;
#(
   parameter int DATA_W = CNN_DATA_W,
   parameter int DEPTH  = CNN_IN_W,
   localparam int IDX_W = idx_width(DEPTH)
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]         rd_idx,
   output logic signed [DATA_W-1:0] rd_data
);

   logic signed [DATA_W-1:0] mem_q [DEPTH];
   logic signed [DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_idx] = wr_data;
      end
   end

   // Contents are don't-care after reset, so no reset term here
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/unpool_layer.sv
// 2x nearest-neighbour unpooling of an IN_W x IN_H frame, one row at a time.
// Define UNPOOL_ZERO_FILL_EN for max-unpool style top-left placement with zeros.
module unpool_layer
   import cnn_pkg::*;
#(
   parameter int DATA_W = CNN_DATA_W,
   parameter int IN_W   = CNN_IN_W,
   parameter int IN_H   = CNN_IN_H
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);

   localparam int ICW = idx_width(IN_W);
   localparam int IRW = idx_width(IN_H);
   localparam int OCW = idx_width(2 * IN_W);

   localparam logic [ICW-1:0] ICOL_LAST = ICW'(IN_W - 1);
   localparam logic [IRW-1:0] IROW_LAST = IRW'(IN_H - 1);
   localparam logic [OCW-1:0] OCOL_LAST = OCW'(2 * IN_W - 1);

   unpool_state_e state_q, state_d;
   logic [ICW-1:0] icol_q, icol_d;
   logic [IRW-1:0] irow_q, irow_d;
   logic [OCW-1:0] ocol_q, ocol_d;

   logic                     buf_wr_en;
   logic [ICW-1:0]           buf_rd_idx;
   logic signed [DATA_W-1:0] buf_rd_data;

   always_comb begin
      state_d   = state_q;
      icol_d    = icol_q;
      irow_d    = irow_q;
      ocol_d    = ocol_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
      case (state_q)
         UNPOOL_IDLE: begin
            if (start) begin
               state_d = UNPOOL_FILL;
               icol_d  = '0;
               irow_d  = '0;
               ocol_d  = '0;
            end
         end
         UNPOOL_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (icol_q == ICOL_LAST) begin
                  state_d = UNPOOL_EMIT0;
                  icol_d  = '0;
               end else begin
                  icol_d = icol_q + 1'b1;
               end
            end
         end
         // The buffered row goes out twice: EMIT0 then EMIT1
         UNPOOL_EMIT0: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (ocol_q == OCOL_LAST) begin
                  state_d = UNPOOL_EMIT1;
                  ocol_d  = '0;
               end else begin
                  ocol_d = ocol_q + 1'b1;
               end
            end
         end
         UNPOOL_EMIT1: begin
            out_valid = 1'b1;
            out_last  = (irow_q == IROW_LAST) && (ocol_q == OCOL_LAST);
            if (out_ready) begin
               if (ocol_q == OCOL_LAST) begin
                  ocol_d = '0;
                  if (irow_q == IROW_LAST) begin
                     state_d = UNPOOL_DONE;
                  end else begin
                     state_d = UNPOOL_FILL;
                     irow_d  = irow_q + 1'b1;
                  end
               end else begin
                  ocol_d = ocol_q + 1'b1;
               end
            end
         end
         UNPOOL_DONE: begin
            done    = 1'b1;
            state_d = UNPOOL_IDLE;
         end
         default: begin
            state_d = UNPOOL_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= UNPOOL_IDLE;
         icol_q  <= '0;
         irow_q  <= '0;
         ocol_q  <= '0;
      end else begin
         state_q <= state_d;
         icol_q  <= icol_d;
         irow_q  <= irow_d;
         ocol_q  <= ocol_d;
      end
   end

   assign busy       = (state_q != UNPOOL_IDLE);
   assign buf_wr_en  = in_valid && in_ready;
   assign buf_rd_idx = ICW'(ocol_q >> 1);

   unpool_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (IN_W)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (buf_wr_en),
      .wr_idx  (icol_q),
      .wr_data (in_data),
      .rd_idx  (buf_rd_idx),
      .rd_data (buf_rd_data)
   );

   // Output is purely a function of held state, so it stays stable during stalls
`ifdef UNPOOL_ZERO_FILL_EN
   assign out_data = ((state_q == UNPOOL_EMIT0) && !ocol_q[0]) ? buf_rd_data : '0;
`else
   assign out_data = buf_rd_data;
`endif

endmodule
